// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream drain stage.
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STOP  = 2'b10,
    FLUSH = 2'b11
  } state_e;

  localparam int SKID_DEPTH = 3;
  localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry first-word-fall-through register buffer; entry 0 is always the head.
module fifo_rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  output logic [1:0]            count_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic [1:0]            r_count;
  logic                  w_pop;
  logic [1:0]            w_wr_idx;

  assign w_pop    = pop_i && (r_count != 2'd0);
  // Entries shift down on a pop, so the write slot moves down with them.
  assign w_wr_idx = r_count - {1'b0, w_pop};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_mem[2] <= '0;
    end else if (clear_i) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_mem[0] <= r_mem[1];
        r_mem[1] <= r_mem[2];
      end
      if (push_i) begin
        case (w_wr_idx)
          2'd0:    r_mem[0] <= push_data_i;
          2'd1:    r_mem[1] <= push_data_i;
          2'd2:    r_mem[2] <= push_data_i;
          default: ;
        endcase
      end
      r_count <= r_count + {1'b0, push_i} - {1'b0, w_pop};
    end
  end

  assign count_o = r_count;
  assign head_o  = r_mem[0];

  overflow_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push_i && !w_pop && !clear_i && (r_count == 2'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO into a valid/ready stream with burst framing and flush.
// Stream handshake: a beat transfers on a cycle where m_valid_o & m_ready_i; while
// m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold, and m_valid_o only drops on flush.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_o,
  output logic                  fifo_oe_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  flush_done_o,
  output logic [1:0]            state_o
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_inflight;
  logic                  r_oe;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic [1:0]            w_occ;
  logic [2:0]            w_pending;
  logic                  w_rd;
  logic                  w_flush_done;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_head;

  // Issue decisions use only registered occupancy, keeping m_ready_i off the read path.
  assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};

  always_comb begin
    w_state_nxt  = r_state;
    w_rd         = 1'b0;
    w_flush_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (flush_i)       w_state_nxt = FLUSH;
        else if (enable_i) w_state_nxt = RUN;
      end
      RUN: begin
        w_rd = !fifo_empty_i && (w_pending < 3'(SKID_DEPTH));
        if (flush_i)        w_state_nxt = FLUSH;
        else if (!enable_i) w_state_nxt = STOP;
      end
      STOP: begin
        // A read from the last RUN cycle lands during this cycle, so one STOP cycle suffices.
        if (flush_i)       w_state_nxt = FLUSH;
        else if (enable_i) w_state_nxt = RUN;
        else               w_state_nxt = IDLE;
      end
      FLUSH: begin
        w_rd = !fifo_empty_i;
        if (fifo_empty_i && !r_inflight) begin
          w_state_nxt  = IDLE;
          w_flush_done = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_oe       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd;
      r_oe       <= 1'b1;
    end
  end

  // Words returning during or at entry to a flush are discarded.
  assign w_push  = r_inflight && (r_state != FLUSH) && !flush_i;
  assign w_valid = (w_occ != 2'd0);
  assign w_pop   = w_valid && m_ready_i;
  assign w_last  = w_valid && (r_beat_cnt == BEAT_CNT_W'(BURST_LEN - 1));

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (w_push),
    .push_data_i (fifo_data_i),
    .pop_i       (w_pop),
    .clear_i     (flush_i),
    .count_o     (w_occ),
    .head_o      (w_head)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_beat_cnt <= '0;
    end else if (flush_i) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
    end
  end

  assign fifo_rd_o    = w_rd;
  assign fifo_oe_o    = r_oe;
  assign m_valid_o    = w_valid;
  assign m_data_o     = w_head;
  assign m_last_o     = w_last;
  assign flush_done_o = w_flush_done;
  assign state_o      = r_state;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  localparam int DW = 18;
  localparam int BL = 16;

  logic          clk_i        = 1'b0;
  logic          rst_n_i      = 1'b0;
  logic          enable_i     = 1'b0;
  logic          flush_i      = 1'b0;
  logic          fifo_empty_i;
  logic [DW-1:0] fifo_data_i  = '0;
  logic          fifo_rd_o;
  logic          fifo_oe_o;
  logic          m_valid_o;
  logic          m_ready_i    = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
  logic          flush_done_o;
  logic [1:0]    state_o;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .flush_i      (flush_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_o    (fifo_rd_o),
    .fifo_oe_o    (fifo_oe_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o),
    .flush_done_o (flush_done_o),
    .state_o      (state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // FIFO model: registered read data, one cycle after an accepted strobe.
  logic [DW-1:0] fifo_mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  assign fifo_empty_i = (rd_ptr == wr_ptr);

  always @(posedge clk_i) begin
    if (fifo_rd_o && !fifo_empty_i) begin
      fifo_data_i <= fifo_mem[rd_ptr[7:0]];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            sb_beat = 0;
  int            lasts_seen = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  typedef struct {
    logic          en;
    logic          rdy;
    logic          push;
    logic [DW-1:0] wdata;
    logic [1:0]    st;
    logic          rd;
    logic          vld;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_mem[wr_ptr[7:0]] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  // Samples on the falling edge: protocol monitors and beat scoreboard.
  task automatic sample();
    logic [DW-1:0] e;
    @(negedge clk_i);
    chk("rd_while_empty", 32'(fifo_rd_o & fifo_empty_i), 32'd0);
    if (stall_prev && m_valid_o) begin
      chk("hold_data", 32'(m_data_o), 32'(stall_data));
      chk("hold_last", 32'(m_last_o), 32'(stall_last));
    end
    if (m_valid_o && m_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", m_data_o, $time);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(m_data_o), 32'(e));
        chk("beat_last", 32'(m_last_o), 32'(sb_beat == BL - 1));
        if (m_last_o) lasts_seen++;
        sb_beat = (sb_beat == BL - 1) ? 0 : sb_beat + 1;
      end
    end
    stall_prev = m_valid_o & ~m_ready_i & ~flush_i & rst_n_i;
    stall_data = m_data_o;
    stall_last = m_last_o;
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic run_vec(input int i);
    enable_i  = vecs[i].en;
    m_ready_i = vecs[i].rdy;
    if (vecs[i].push) push_word(vecs[i].wdata);
    sample();
    chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
    chk($sformatf("vec%0d_rd", i), 32'(fifo_rd_o), 32'(vecs[i].rd));
    chk($sformatf("vec%0d_valid", i), 32'(m_valid_o), 32'(vecs[i].vld));
    advance();
  endtask

  initial begin
    int vcnt;
    int done_cnt;
    int done_at;

    // Drain start: enable driven in row 0, first beat visible in row 3.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 18'h0,     IDLE, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 18'h0,     RUN,  1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 18'h0,     RUN,  1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 18'h0,     RUN,  1'b1, 1'b1};
    // Disable in the same cycle as a read strobe, then re-enable.
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 18'h00100, RUN,  1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 18'h00101, STOP, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 18'h0,     IDLE, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 18'h0,     IDLE, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 18'h0,     IDLE, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 18'h0,     RUN,  1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 18'h0,     RUN,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 18'h0,     RUN,  1'b0, 1'b1};

    // Reset values
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    sample();
    chk("rst_rd", 32'(fifo_rd_o), 32'd0);
    chk("rst_oe", 32'(fifo_oe_o), 32'd0);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_data", 32'(m_data_o), 32'd0);
    chk("rst_last", 32'(m_last_o), 32'd0);
    chk("rst_done", 32'(flush_done_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'(IDLE));
    rst_n_i = 1'b1;
    advance();
    chk("oe_after_release", 32'(fifo_oe_o), 32'd1);
    chk("idle_after_release", 32'(state_o), 32'(IDLE));

    // Continuous drain of 32 words
    m_ready_i = 1'b1;
    for (int k = 1; k <= 32; k++) push_word(DW'(k));
    lasts_seen = 0;
    for (int i = 0; i < 4; i++) run_vec(i);
    vcnt = 0;
    for (int c = 0; c < 31; c++) begin
      sample();
      if (m_valid_o) vcnt++;
      advance();
    end
    chk("drain_back_to_back", 32'(vcnt), 32'd31);
    chk("drain_all_delivered", 32'(exp_q.size()), 32'd0);
    chk("drain_lasts", 32'(lasts_seen), 32'd2);
    sample();
    chk("drain_valid_low_when_empty", 32'(m_valid_o), 32'd0);
    advance();

    // Backpressure mid-stream
    for (int k = 33; k <= 52; k++) push_word(DW'(k));
    repeat (5) step();
    m_ready_i = 1'b0;
    for (int s = 0; s < 10; s++) begin
      sample();
      if (s == 9) begin
        chk("bp_rd_stopped", 32'(fifo_rd_o), 32'd0);
        chk("bp_valid_held", 32'(m_valid_o), 32'd1);
      end
      advance();
    end
    m_ready_i = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) step();
    chk("bp_all_delivered", 32'(exp_q.size()), 32'd0);

    // Empty boundary
    for (int k = 53; k <= 55; k++) push_word(DW'(k));
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    chk("empty_three_delivered", 32'(exp_q.size()), 32'd0);
    vcnt = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (m_valid_o) vcnt++;
      advance();
    end
    chk("empty_no_valid", 32'(vcnt), 32'd0);
    push_word(18'h00038);
    sample();
    chk("empty_w4_rd", 32'(fifo_rd_o), 32'd1);
    chk("empty_w4_c0_valid", 32'(m_valid_o), 32'd0);
    advance();
    sample();
    chk("empty_w4_c1_valid", 32'(m_valid_o), 32'd0);
    advance();
    sample();
    chk("empty_w4_c2_valid", 32'(m_valid_o), 32'd1);
    advance();
    chk("empty_w4_consumed", 32'(exp_q.size()), 32'd0);

    // Disable mid-read and re-enable
    for (int i = 4; i < 12; i++) run_vec(i);
    chk("disable_all_delivered", 32'(exp_q.size()), 32'd0);

    // Flush with two words buffered and eight in the FIFO
    m_ready_i = 1'b0;
    push_word(18'h00200);
    push_word(18'h00201);
    repeat (4) step();
    enable_i = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 8; k++) push_word(DW'(18'h00300 + k));
    sample();
    chk("pre_flush_state", 32'(state_o), 32'(IDLE));
    chk("pre_flush_valid", 32'(m_valid_o), 32'd1);
    chk("pre_flush_head", 32'(m_data_o), 32'h00200);
    advance();
    flush_i = 1'b1;
    sample();
    advance();
    flush_i   = 1'b0;
    exp_q.delete();
    sb_beat   = 0;
    m_ready_i = 1'b1;
    done_cnt  = 0;
    done_at   = -1;
    vcnt      = 0;
    for (int c = 1; c <= 15; c++) begin
      sample();
      if (c == 1) begin
        chk("flush_state", 32'(state_o), 32'(FLUSH));
        chk("flush_rd", 32'(fifo_rd_o), 32'd1);
      end
      if (m_valid_o) vcnt++;
      if (flush_done_o) begin
        done_cnt++;
        done_at = c;
      end
      advance();
    end
    chk("flush_no_valid", 32'(vcnt), 32'd0);
    chk("flush_done_once", 32'(done_cnt), 32'd1);
    chk("flush_done_cycle", 32'(done_at), 32'd10);
    chk("flush_end_state", 32'(state_o), 32'(IDLE));
    chk("flush_fifo_empty", 32'(fifo_empty_i), 32'd1);

    // Next burst counts from zero after flush
    enable_i   = 1'b1;
    lasts_seen = 0;
    for (int k = 0; k < 16; k++) push_word(DW'(18'h00400 + k));
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) step();
    chk("post_flush_delivered", 32'(exp_q.size()), 32'd0);
    chk("post_flush_lasts", 32'(lasts_seen), 32'd1);

    // Asynchronous reset with two words buffered
    m_ready_i = 1'b0;
    push_word(18'h00500);
    push_word(18'h00501);
    repeat (4) step();
    chk("pre_reset_valid", 32'(m_valid_o), 32'd1);
    chk("pre_reset_head", 32'(m_data_o), 32'h00500);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid_o), 32'd0);
    chk("arst_data", 32'(m_data_o), 32'd0);
    chk("arst_last", 32'(m_last_o), 32'd0);
    chk("arst_oe", 32'(fifo_oe_o), 32'd0);
    chk("arst_rd", 32'(fifo_rd_o), 32'd0);
    chk("arst_state", 32'(state_o), 32'(IDLE));
    exp_q.delete();
    sb_beat    = 0;
    stall_prev = 1'b0;
    enable_i   = 1'b0;
    advance();
    rst_n_i = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (m_valid_o) vcnt++;
      advance();
    end
    chk("post_reset_no_valid", 32'(vcnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
